// File: rtl/matrix_scan_driver.sv
// Row-multiplexed LED matrix driver: fetches one ROM row, shifts it MSB-first into an
// external shift-register chain, latches it and lights the row for a fixed dwell time.
module matrix_scan_driver #(
  parameter int NUM_ROWS     = 5,
  parameter int DWELL_CYCLES = 1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  output logic [4:0]  addRom,
  input  logic [31:0] dataRom,
  output logic        ser_data,
  output logic        ser_clk,
  output logic        ser_latch,
  output logic [4:0]  row_sel,
  output logic        row_en,
  output logic        frame_done
);

  localparam int             DW         = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
  localparam logic [4:0]     LAST_ROW   = 5'(NUM_ROWS - 1);
  localparam logic [DW-1:0]  DWELL_LOAD = DW'(DWELL_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, FETCH, SHIFT, LATCH, DISPLAY} state_t;

  state_t        state_q, state_d;
  logic [4:0]    row_q, row_d;
  logic [4:0]    addr_q, addr_d;
  logic [4:0]    row_sel_q, row_sel_d;
  logic [31:0]   shreg_q, shreg_d;
  logic [5:0]    bit_cnt_q, bit_cnt_d;
  logic [DW-1:0] dwell_q, dwell_d;
  logic          frame_done_q, frame_done_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      row_q        <= '0;
      addr_q       <= '0;
      row_sel_q    <= '0;
      shreg_q      <= '0;
      bit_cnt_q    <= '0;
      dwell_q      <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      row_q        <= row_d;
      addr_q       <= addr_d;
      row_sel_q    <= row_sel_d;
      shreg_q      <= shreg_d;
      bit_cnt_q    <= bit_cnt_d;
      dwell_q      <= dwell_d;
      frame_done_q <= frame_done_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    row_d        = row_q;
    addr_d       = addr_q;
    row_sel_d    = row_sel_q;
    shreg_d      = shreg_q;
    bit_cnt_d    = bit_cnt_q;
    dwell_d      = dwell_q;
    frame_done_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (enable) state_d = FETCH;
      end
      FETCH: begin
        addr_d    = row_q;
        shreg_d   = dataRom;
        bit_cnt_d = '0;
        state_d   = SHIFT;
      end
      // Even count = ser_clk low phase, odd count = high phase; advance the bit after the high phase.
      SHIFT: begin
        bit_cnt_d = bit_cnt_q + 6'd1;
        if (bit_cnt_q[0]) shreg_d = {shreg_q[30:0], 1'b0};
        if (bit_cnt_q == 6'd63) begin
          row_sel_d = row_q;
          state_d   = LATCH;
        end
      end
      LATCH: begin
        dwell_d = DWELL_LOAD;
        state_d = DISPLAY;
      end
      DISPLAY: begin
        if (dwell_q == '0) begin
          frame_done_d = (row_q == LAST_ROW);
          row_d        = (row_q == LAST_ROW) ? 5'd0 : row_q + 5'd1;
          state_d      = enable ? FETCH : IDLE;
        end else begin
          dwell_d = dwell_q - DW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign addRom     = (state_q == FETCH) ? row_q : addr_q;
  assign ser_data   = (state_q == SHIFT) & shreg_q[31];
  assign ser_clk    = (state_q == SHIFT) & bit_cnt_q[0];
  assign ser_latch  = (state_q == LATCH);
  assign row_sel    = row_sel_q;
  assign row_en     = (state_q == DISPLAY);
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_matrix_scan_driver.sv
// Self-checking bench for matrix_scan_driver: table-driven rows, randomized rows against a
// row-level reference model, reset corner cases and frame timing for NUM_ROWS=5 and NUM_ROWS=1.
module tb_matrix_scan_driver;

  localparam int NR      = 5;
  localparam int DW      = 4;
  localparam int PERIOD  = 66 + DW;
  localparam int DW1     = 3;
  localparam int PERIOD1 = 66 + DW1;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        enable1;
  logic [4:0]  add_rom, add_rom1;
  logic [31:0] data_rom;
  logic        ser_data, ser_clk, ser_latch, row_en, frame_done;
  logic [4:0]  row_sel;
  logic        ser_data1, ser_clk1, ser_latch1, row_en1, frame_done1;
  logic [4:0]  row_sel1;
  logic [31:0] rom [32];

  int tests_run    = 0;
  int tests_failed = 0;

  typedef struct packed {
    logic [31:0] word;
    logic        drop;
    logic [6:0]  drop_at;
    logic [3:0]  idle_cycles;
    logic [4:0]  exp_row;
    logic        exp_fd;
  } vec_t;

  vec_t vecs [6];

  assign data_rom = rom[add_rom];

  always #5 clk = ~clk;

  matrix_scan_driver #(.NUM_ROWS(NR), .DWELL_CYCLES(DW)) dut (
    .clk(clk), .rst(rst), .enable(enable), .addRom(add_rom), .dataRom(data_rom),
    .ser_data(ser_data), .ser_clk(ser_clk), .ser_latch(ser_latch), .row_sel(row_sel),
    .row_en(row_en), .frame_done(frame_done)
  );

  matrix_scan_driver #(.NUM_ROWS(1), .DWELL_CYCLES(DW1)) dut1 (
    .clk(clk), .rst(rst), .enable(enable1), .addRom(add_rom1), .dataRom(32'hDEAD_BEEF),
    .ser_data(ser_data1), .ser_clk(ser_clk1), .ser_latch(ser_latch1), .row_sel(row_sel1),
    .row_en(row_en1), .frame_done(frame_done1)
  );

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Starts at the sample point of a FETCH cycle, ends at the sample point of the cycle after DISPLAY.
  task automatic checkRow(input logic [4:0] exp_row, input logic [31:0] word,
                          input int drop_at, input int stop_at);
    int addr_err = 0, clk_err = 0, data_err = 0, latch_err = 0;
    int sel_err = 0, en_err = 0, en_cnt = 0, fd_err = 0, edges = 0;
    logic [31:0] got = '0;
    logic prev_clk = 1'b0;
    for (int c = 0; c < PERIOD; c++) begin
      logic in_shift, exp_clk, exp_data;
      int k;
      if (c == stop_at) return;
      k        = c - 1;
      in_shift = (c >= 1) && (c <= 64);
      exp_clk  = in_shift && (k % 2 == 1);
      exp_data = in_shift ? word[31 - k / 2] : 1'b0;
      if (add_rom !== exp_row) addr_err++;
      if (ser_clk !== exp_clk) clk_err++;
      if (ser_data !== exp_data) data_err++;
      if (ser_clk && !prev_clk) begin
        got = {got[30:0], ser_data};
        edges++;
      end
      if (ser_latch !== (c == 65)) latch_err++;
      if (row_en !== (c >= 66)) en_err++;
      if (row_en === 1'b1) en_cnt++;
      if (c >= 65 && row_sel !== exp_row) sel_err++;
      if (c > 0 && frame_done !== 1'b0) fd_err++;
      if (c == drop_at) enable = 1'b0;
      prev_clk = ser_clk;
      @(negedge clk);
    end
    checkOutput("addRom", addr_err, 0);
    checkOutput("serClk", clk_err, 0);
    checkOutput("serData", data_err, 0);
    checkOutput("serBits", int'(got), int'(word));
    checkOutput("serEdges", edges, 32);
    checkOutput("serLatch", latch_err, 0);
    checkOutput("rowSel", sel_err, 0);
    checkOutput("rowEnWindow", en_err, 0);
    checkOutput("dwellCycles", en_cnt, DW);
    checkOutput("midRowFrameDone", fd_err, 0);
  endtask

  task automatic idleCycles(input logic [4:0] held_row, input int n);
    int errs = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if ({row_en, ser_clk, ser_data, ser_latch, frame_done} !== 5'b0) errs++;
      if (add_rom !== held_row) errs++;
    end
    checkOutput("idleQuiet", errs, 0);
  endtask

  task automatic applyStimulus(input vec_t v);
    rom[v.exp_row] = v.word;
    checkRow(v.exp_row, v.word, v.drop ? int'(v.drop_at) : -1, -1);
    checkOutput("frameDone", int'(frame_done), int'(v.exp_fd));
    if (v.drop) begin
      idleCycles(v.exp_row, int'(v.idle_cycles));
      enable = 1'b1;
      @(negedge clk);
    end
  endtask

  initial begin
    int exp_row;
    int drop_at;
    int q [$];
    int errs;
    logic dropped;
    logic [31:0] word;

    vecs[0] = '{32'h0000_0004, 1'b0, 7'd0,  4'd0, 5'd0, 1'b0};
    vecs[1] = '{32'h00FF_FFFF, 1'b0, 7'd0,  4'd0, 5'd1, 1'b0};
    vecs[2] = '{32'hA5A5_0F0F, 1'b1, 7'd11, 4'd6, 5'd2, 1'b0};
    vecs[3] = '{32'h8000_0001, 1'b0, 7'd0,  4'd0, 5'd3, 1'b0};
    vecs[4] = '{32'hFFFF_FFFF, 1'b0, 7'd0,  4'd0, 5'd4, 1'b1};
    vecs[5] = '{32'h0000_0000, 1'b0, 7'd0,  4'd0, 5'd0, 1'b0};
    for (int i = 0; i < 32; i++) rom[i] = '0;

    rst = 1'b1;
    enable = 1'b0;
    enable1 = 1'b0;
    @(negedge clk);
    checkOutput("resetOutputs",
                int'({add_rom, ser_data, ser_clk, ser_latch, row_sel, row_en, frame_done}), 0);
    rst = 1'b0;
    idleCycles(5'd0, 3);

    enable = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 6; i++) applyStimulus(vecs[i]);

    // Random rows; the model only tracks which row must come next.
    exp_row = 1;
    for (int i = 0; i < 12; i++) begin
      word    = $urandom;
      dropped = ($urandom_range(0, 2) == 0);
      drop_at = dropped ? int'($urandom_range(0, PERIOD - 1)) : -1;
      rom[exp_row] = word;
      checkRow(5'(exp_row), word, drop_at, -1);
      checkOutput("frameDone", int'(frame_done), int'(exp_row == NR - 1));
      if (dropped) begin
        idleCycles(5'(exp_row), int'($urandom_range(1, 8)));
        enable = 1'b1;
        @(negedge clk);
      end
      exp_row = (exp_row + 1) % NR;
    end

    repeat (10) @(negedge clk);
    rst = 1'b1;
    #1;
    checkOutput("resetMidShift",
                int'({add_rom, ser_data, ser_clk, ser_latch, row_sel, row_en, frame_done}), 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    for (int r = 0; r < 3; r++) begin
      rom[r] = 32'h1357_0000 + 32'(r);
      checkRow(5'(r), rom[r], -1, -1);
    end
    rom[3] = 32'hCAFE_F00D;
    checkRow(5'd3, rom[3], -1, 68);
    rst = 1'b1;
    #1;
    checkOutput("resetInDisplay", int'({row_en, row_sel, add_rom, ser_latch, frame_done}), 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rom[0] = 32'h0F0F_1234;
    checkRow(5'd0, rom[0], -1, -1);

    errs = 0;
    for (int t = 0; t < 800; t++) begin
      if (frame_done === 1'b1) q.push_back(t);
      @(negedge clk);
    end
    checkOutput("framePulseCount", q.size(), 2);
    if (q.size() >= 2) begin
      checkOutput("firstFramePulse", q[0], 4 * PERIOD);
      checkOutput("framePeriod", q[1] - q[0], NR * PERIOD);
    end

    q.delete();
    enable = 1'b0;
    enable1 = 1'b1;
    @(negedge clk);
    for (int t = 0; t < 300; t++) begin
      if (frame_done1 === 1'b1) q.push_back(t);
      if (add_rom1 !== 5'd0 || row_sel1 !== 5'd0) errs++;
      @(negedge clk);
    end
    checkOutput("oneRowAddr", errs, 0);
    checkOutput("oneRowPulseCount", q.size(), 4);
    errs = 0;
    for (int i = 0; i < q.size(); i++) begin
      if (q[i] != (i + 1) * PERIOD1) errs++;
    end
    checkOutput("oneRowFramePeriod", errs, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
